uart_cfg_ctrl: RTL and testbench

Frame controller that sits behind the clkx16 UART receiver and turns its byte stream into configuration writes for the VU-meter datapath. It sequences 4-byte frames (SYNC, ADDR, DATA, CHK), validates them, updates one of four configuration registers and reports frame success and failure. It also maintains a saturating error counter covering checksum, address, timeout and UART framing errors.

---
 rtl/uart_ctrl_pkg.sv | 27 ++
 rtl/ctrl_timeout.sv | 38 +++
 rtl/uart_cfg_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_cfg_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART configuration frame controller:
// FSM state encoding, default SYNC byte, register addresses and the
// frame checksum helper.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    GET_CHK  = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [1:0] ADDR_GAIN   = 2'd0;
  localparam logic [1:0] ADDR_THRESH = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;
  localparam logic [1:0] ADDR_DECAY  = 2'd3;

  // Expected CHK byte of a frame
  function automatic logic [7:0] frame_chk(input logic [7:0] sync,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return sync ^ addr ^ data;
  endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// Inter-byte timeout counter.
// Ports: clkx16/reset_n clock and async active-low reset; run enables
// counting; restart zeroes the count; expired is high while the count
// sits at TIMEOUT_CYC-1 and run is set.
module ctrl_timeout #(
  parameter int unsigned TIMEOUT_CYC = 640
) (
  input  logic clkx16,
  input  logic reset_n,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == CNT_LAST);

  // Count while running; clear when stopped, restarted or on expiry
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!run || restart || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clkx16 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cfg_ctrl.sv
// UART configuration frame controller. Sequences SYNC/ADDR/DATA/CHK
// frames from the UART receiver into writes of four config registers,
// reports frame_ok / frame_err pulses and keeps a saturating error count.
// Ports: clkx16, reset_n (async active-low); rx_data/rx_load byte strobe;
// rx_error receiver stop-bit error level; err_clr clears err_count;
// cfg_gain/thresh/mode/decay register outputs; frame_ok, frame_err pulses;
// err_count; busy (FSM outside IDLE).
module uart_cfg_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [7:0]  SYNC        = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 640,
  parameter logic [7:0]  GAIN_RST    = 8'h10,
  parameter logic [7:0]  THRESH_RST  = 8'h80,
  parameter logic [7:0]  MODE_RST    = 8'h00,
  parameter logic [7:0]  DECAY_RST   = 8'h04
) (
  input  logic       clkx16,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_load,
  input  logic       rx_error,
  input  logic       err_clr,
  output logic [7:0] cfg_gain,
  output logic [7:0] cfg_thresh,
  output logic [7:0] cfg_mode,
  output logic [7:0] cfg_decay,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d, data_q, data_d;
  logic [7:0] gain_q, gain_d, thresh_q, thresh_d;
  logic [7:0] mode_q, mode_d, decay_q, decay_d;
  logic [7:0] errcnt_q, errcnt_d;
  logic       ok_q, ok_d, ferr_q, ferr_d, busy_q, busy_d;
  logic       rxerr_q;
  logic       err_rise, err_inc, tmo_expired, tmo_restart;

  assign err_rise    = rx_error && !rxerr_q;
  assign tmo_restart = rx_load || (state_d == IDLE);

  ctrl_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clkx16  (clkx16),
    .reset_n (reset_n),
    .run     (state_q != IDLE),
    .restart (tmo_restart),
    .expired (tmo_expired)
  );

  // Frame sequencing, register writes and error accounting.
  // Priority: rx_error edge > rx_load > timeout.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    gain_d   = gain_q;
    thresh_d = thresh_q;
    mode_d   = mode_q;
    decay_d  = decay_q;
    ok_d     = 1'b0;
    ferr_d   = 1'b0;
    err_inc  = 1'b0;

    if (err_rise) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      err_inc = 1'b1;
    end else if (rx_load) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC) state_d = GET_ADDR;
        end
        GET_ADDR: begin
          addr_d  = rx_data;
          state_d = GET_DATA;
        end
        GET_DATA: begin
          data_d  = rx_data;
          state_d = GET_CHK;
        end
        default: begin
          state_d = IDLE;
          if ((rx_data == frame_chk(SYNC, addr_q, data_q)) && (addr_q[7:2] == 6'd0)) begin
            ok_d = 1'b1;
            case (addr_q[1:0])
              ADDR_GAIN:   gain_d   = data_q;
              ADDR_THRESH: thresh_d = data_q;
              ADDR_MODE:   mode_d   = data_q;
              default:     decay_d  = data_q;
            endcase
          end else begin
            ferr_d  = 1'b1;
            err_inc = 1'b1;
          end
        end
      endcase
    end else if (tmo_expired) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      err_inc = 1'b1;
    end

    // Clear beats a coincident increment; saturate at 255
    errcnt_d = errcnt_q;
    if (err_clr) begin
      errcnt_d = '0;
    end else if (err_inc && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clkx16 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      gain_q   <= GAIN_RST;
      thresh_q <= THRESH_RST;
      mode_q   <= MODE_RST;
      decay_q  <= DECAY_RST;
      errcnt_q <= '0;
      ok_q     <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      rxerr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      gain_q   <= gain_d;
      thresh_q <= thresh_d;
      mode_q   <= mode_d;
      decay_q  <= decay_d;
      errcnt_q <= errcnt_d;
      ok_q     <= ok_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
      rxerr_q  <= rx_error;
    end
  end

  assign cfg_gain   = gain_q;
  assign cfg_thresh = thresh_q;
  assign cfg_mode   = mode_q;
  assign cfg_decay  = decay_q;
  assign frame_ok   = ok_q;
  assign frame_err  = ferr_q;
  assign err_count  = errcnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Self-checking bench for uart_cfg_ctrl: frame vector table, hand-written
// corner sequences and random byte streams against a frame-level model.
module tb_uart_cfg_ctrl;

  localparam int unsigned TO = 640;
  localparam logic [7:0]  SY = 8'hA5;

  logic       clkx16 = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_load, rx_error, err_clr;
  logic [7:0] cfg_gain, cfg_thresh, cfg_mode, cfg_decay, err_count;
  logic       frame_ok, frame_err, busy;

  uart_cfg_ctrl dut (
    .clkx16     (clkx16),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_load    (rx_load),
    .rx_error   (rx_error),
    .err_clr    (err_clr),
    .cfg_gain   (cfg_gain),
    .cfg_thresh (cfg_thresh),
    .cfg_mode   (cfg_mode),
    .cfg_decay  (cfg_decay),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 clkx16 = ~clkx16;

  int n_checks = 0;
  int n_fail   = 0;
  bit err_lvl  = 1'b0;

  // Frame-level reference model
  logic [7:0] m_cfg [4];
  logic [7:0] m_cnt;
  bit         m_ok, m_ferr, m_errprev;
  logic [7:0] m_frm [$];
  int         m_idle;

  function automatic void model_reset();
    m_cfg[0] = 8'h10; m_cfg[1] = 8'h80; m_cfg[2] = 8'h00; m_cfg[3] = 8'h04;
    m_cnt = 8'd0; m_ok = 1'b0; m_ferr = 1'b0; m_errprev = 1'b0;
    m_frm.delete(); m_idle = 0;
  endfunction

  function automatic void model_step(bit ld, logic [7:0] d, bit el, bit clr);
    bit rise = el && !m_errprev;
    bit inc  = 1'b0;
    m_errprev = el;
    m_ok = 1'b0;
    m_ferr = 1'b0;
    if (rise) begin
      m_ferr = 1'b1; inc = 1'b1; m_frm.delete();
    end else if (ld) begin
      m_idle = 0;
      if (m_frm.size() == 0) begin
        if (d == SY) m_frm.push_back(d);
      end else if (m_frm.size() < 3) begin
        m_frm.push_back(d);
      end else begin
        if (((m_frm[0] ^ m_frm[1] ^ m_frm[2]) == d) && (m_frm[1] < 8'd4)) begin
          m_cfg[int'(m_frm[1])] = m_frm[2];
          m_ok = 1'b1;
        end else begin
          m_ferr = 1'b1; inc = 1'b1;
        end
        m_frm.delete();
      end
    end else if (m_frm.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_ferr = 1'b1; inc = 1'b1; m_frm.delete();
      end
    end
    if (clr) m_cnt = 8'd0;
    else if (inc && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("cfg_gain",   32'(cfg_gain),   32'(m_cfg[0]));
    chk("cfg_thresh", 32'(cfg_thresh), 32'(m_cfg[1]));
    chk("cfg_mode",   32'(cfg_mode),   32'(m_cfg[2]));
    chk("cfg_decay",  32'(cfg_decay),  32'(m_cfg[3]));
    chk("frame_ok",   32'(frame_ok),   32'(m_ok));
    chk("frame_err",  32'(frame_err),  32'(m_ferr));
    chk("err_count",  32'(err_count),  32'(m_cnt));
    chk("busy",       32'(busy),       32'(m_frm.size() > 0));
  endtask

  // One clock: drive at negedge, model the posedge, compare at next negedge
  task automatic tick(input bit ld, input logic [7:0] d, input bit clr);
    rx_load  = ld;
    rx_data  = ld ? d : 8'($urandom);
    rx_error = err_lvl;
    err_clr  = clr;
    model_step(ld, d, err_lvl, clr);
    @(negedge clkx16);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    tick(1'b1, SY, 1'b0);
    tick(1'b1, a, 1'b0);
    tick(1'b1, d, 1'b0);
    tick(1'b1, c, 1'b0);
  endtask

  function automatic logic [7:0] dut_cfg(input int i);
    case (i)
      0:       return cfg_gain;
      1:       return cfg_thresh;
      2:       return cfg_mode;
      default: return cfg_decay;
    endcase
  endfunction

  typedef struct {
    logic [7:0] a, d, c;
    bit         ok;
    int         idx;
    logic [7:0] val;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{a: 8'h01, d: 8'h3C, c: 8'h98, ok: 1'b1, idx: 1, val: 8'h3C, cnt: 8'd0};
    vt[1] = '{a: 8'h00, d: 8'h22, c: 8'h00, ok: 1'b0, idx: 0, val: 8'h10, cnt: 8'd1};
    vt[2] = '{a: 8'h00, d: 8'h22, c: 8'h87, ok: 1'b1, idx: 0, val: 8'h22, cnt: 8'd1};
    vt[3] = '{a: 8'h04, d: 8'h11, c: 8'hB0, ok: 1'b0, idx: 0, val: 8'h22, cnt: 8'd2};
    vt[4] = '{a: 8'h02, d: 8'h01, c: 8'hA6, ok: 1'b1, idx: 2, val: 8'h01, cnt: 8'd2};
    vt[5] = '{a: 8'hA5, d: 8'h07, c: 8'h07, ok: 1'b0, idx: 1, val: 8'h3C, cnt: 8'd3};
    vt[6] = '{a: 8'h03, d: 8'hFF, c: 8'h59, ok: 1'b1, idx: 3, val: 8'hFF, cnt: 8'd3};

    reset_n = 1'b0; rx_load = 1'b0; rx_data = 8'h00; rx_error = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clkx16);
    chk("rst_gain",   32'(cfg_gain),   32'h10);
    chk("rst_thresh", 32'(cfg_thresh), 32'h80);
    chk("rst_mode",   32'(cfg_mode),   32'h00);
    chk("rst_decay",  32'(cfg_decay),  32'h04);
    chk("rst_busy",   32'(busy),       32'h0);
    chk("rst_errcnt", 32'(err_count),  32'h0);
    chk("rst_ok",     32'(frame_ok),   32'h0);
    chk("rst_ferr",   32'(frame_err),  32'h0);
    reset_n = 1'b1;

    // Back-to-back frame table; garbage byte in IDLE first is silently ignored
    tick(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send4(vt[i].a, vt[i].d, vt[i].c);
      chk($sformatf("vec%0d_ok", i),  32'(frame_ok),        32'(vt[i].ok));
      chk($sformatf("vec%0d_err", i), 32'(frame_err),       32'(!vt[i].ok));
      chk($sformatf("vec%0d_cfg", i), 32'(dut_cfg(vt[i].idx)), 32'(vt[i].val));
      chk($sformatf("vec%0d_cnt", i), 32'(err_count),       32'(vt[i].cnt));
    end
    idle(2);

    // Timeout after ADDR: abort on the 640th idle cycle
    tick(1'b1, SY, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    idle(TO - 1);
    chk("tmo_early_busy", 32'(busy), 32'h1);
    chk("tmo_early_err",  32'(frame_err), 32'h0);
    idle(1);
    chk("tmo_err",  32'(frame_err), 32'h1);
    chk("tmo_busy", 32'(busy), 32'h0);
    chk("tmo_cnt",  32'(err_count), 32'd4);
    send4(8'h02, 8'h01, 8'hA6);
    chk("tmo_then_mode", 32'(cfg_mode), 32'h01);

    // Load arriving exactly at expiry wins
    tick(1'b1, SY, 1'b0);
    idle(TO - 1);
    tick(1'b1, 8'h01, 1'b0);
    chk("tmo_race_err",  32'(frame_err), 32'h0);
    chk("tmo_race_busy", 32'(busy), 32'h1);
    tick(1'b1, 8'h77, 1'b0);
    tick(1'b1, 8'hD3, 1'b0);
    chk("tmo_race_thresh", 32'(cfg_thresh), 32'h77);

    // rx_error rising in GET_DATA aborts; held level is harmless; clear
    tick(1'b1, SY, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    err_lvl = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    chk("uerr_err",  32'(frame_err), 32'h1);
    chk("uerr_busy", 32'(busy), 32'h0);
    chk("uerr_cnt",  32'(err_count), 32'd5);
    idle(5);
    send4(8'h00, 8'h5A, 8'hFF);
    chk("uerr_held_cnt",  32'(err_count), 32'd5);
    chk("uerr_held_gain", 32'(cfg_gain), 32'h5A);
    tick(1'b0, 8'h00, 1'b1);
    chk("uerr_clr", 32'(err_count), 32'd0);

    // rx_error edge coincident with a byte load: abort, single increment
    err_lvl = 1'b0;
    idle(1);
    tick(1'b1, SY, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    err_lvl = 1'b1;
    tick(1'b1, 8'h55, 1'b0);
    chk("race_err",  32'(frame_err), 32'h1);
    chk("race_busy", 32'(busy), 32'h0);
    chk("race_cnt",  32'(err_count), 32'd1);
    err_lvl = 1'b0;
    idle(1);

    // err_clr with a coincident new error yields 0
    tick(1'b1, SY, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h00, 1'b1);
    chk("clr_pri_err", 32'(frame_err), 32'h1);
    chk("clr_pri_cnt", 32'(err_count), 32'd0);

    // Saturation
    for (int i = 0; i < 300; i++) send4(8'h00, 8'h00, 8'h00);
    chk("sat_cnt", 32'(err_count), 32'd255);

    // Reset mid-frame
    tick(1'b1, SY, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    reset_n = 1'b0; rx_load = 1'b0; rx_error = 1'b0; err_lvl = 1'b0;
    #1;
    chk("mid_rst_gain",   32'(cfg_gain),   32'h10);
    chk("mid_rst_thresh", 32'(cfg_thresh), 32'h80);
    chk("mid_rst_mode",   32'(cfg_mode),   32'h00);
    chk("mid_rst_decay",  32'(cfg_decay),  32'h04);
    chk("mid_rst_busy",   32'(busy),       32'h0);
    chk("mid_rst_cnt",    32'(err_count),  32'h0);
    model_reset();
    @(negedge clkx16);
    reset_n = 1'b1;
    idle(1);

    // Random byte streams against the model
    for (int it = 0; it < 400; it++) begin
      int r = $urandom_range(0, 9);
      if (r <= 4) begin
        logic [7:0] a, d, c;
        a = ($urandom_range(0, 7) < 6) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        d = 8'($urandom);
        c = SY ^ a ^ d;
        if ($urandom_range(0, 5) == 0) c = c ^ (8'd1 << $urandom_range(0, 7));
        tick(1'b1, SY, 1'b0);
        idle($urandom_range(0, 3));
        tick(1'b1, a, 1'b0);
        idle($urandom_range(0, 3));
        tick(1'b1, d, 1'b0);
        idle($urandom_range(0, 3));
        tick(1'b1, c, 1'b0);
      end else if (r == 5) begin
        tick(1'b1, 8'($urandom), 1'b0);
      end else if (r == 6) begin
        idle($urandom_range(1, 5));
      end else if (r == 7) begin
        err_lvl = ($urandom_range(0, 1) == 1);
        tick(1'b0, 8'h00, 1'b0);
      end else if (r == 8) begin
        tick(1'b0, 8'h00, 1'b1);
      end else begin
        tick(1'b1, SY, 1'b0);
        if ($urandom_range(0, 1) == 1) tick(1'b1, 8'($urandom), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
